// File: rtl/tt_um_nibble_adder_checker_pkg.sv
// Shared definitions for the nibble adder checker: state encoding,
// default settle time, status bit positions and error saturation value.
package tt_um_nibble_adder_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int SETTLE_CYCLES_DEF = 2;

    localparam int BUSY_BIT = 0;
    localparam int DONE_BIT = 1;
    localparam int PASS_BIT = 2;
    localparam int ZERO_BIT = 3;

    localparam logic [3:0] ERR_SAT = 4'd15;

endpackage

// File: rtl/tt_um_nibble_adder_checker_nibble_sum_ref.sv
// Combinational golden adder: the full 5-bit sum of two nibbles,
// used as the expected value for every returned sum.
module nibble_sum_ref (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [4:0] sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/tt_um_nibble_adder_checker.sv
// Sweeps all 256 operand pairs into an external 4+4-bit adder, waits a
// settle time per vector, compares the returned sum with a golden sum and
// reports busy/done/pass, a saturating error count and the first failing pair.
module tt_um_nibble_adder_checker
    import tt_um_nibble_adder_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t     state_q, state_d;
    logic [7:0] vector_q, vector_d;
    logic [3:0] settleCnt_q, settleCnt_d;
    logic [3:0] errCount_q, errCount_d;
    logic [7:0] firstFail_q, firstFail_d;
    logic       failSeen_q, failSeen_d;

    logic       startS1_q, startS2_q, startPrev_q;
    logic       abortS1_q, abortS2_q;
    logic       syncValid1_q, syncValid2_q, startArmed_q;

    logic       startEdge;
    logic       busy;
    logic       sumMismatch;
    logic [4:0] expSum;
    logic [7:0] statusBits;
    logic       unusedInputs;

    assign unusedInputs = ^{ena, uio_in};

    nibble_sum_ref uSumRef (
        .a_i   (vector_q[3:0]),
        .b_i   (vector_q[7:4]),
        .sum_o (expSum)
    );

    assign sumMismatch = (ui_in[4:0] != expSum);
    assign busy        = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);

    // A start edge only counts once the synchronizer holds real samples and has
    // seen start low, so a start held high across reset release cannot launch a run.
    assign startEdge = startArmed_q && startS2_q && !startPrev_q;

    // Synchronize start/abort and track when the start edge detector may be trusted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            startS1_q    <= 1'b0;
            startS2_q    <= 1'b0;
            startPrev_q  <= 1'b0;
            abortS1_q    <= 1'b0;
            abortS2_q    <= 1'b0;
            syncValid1_q <= 1'b0;
            syncValid2_q <= 1'b0;
            startArmed_q <= 1'b0;
        end else begin
            startS1_q    <= ui_in[7];
            startS2_q    <= startS1_q;
            startPrev_q  <= startS2_q;
            abortS1_q    <= ui_in[6];
            abortS2_q    <= abortS1_q;
            syncValid1_q <= 1'b1;
            syncValid2_q <= syncValid1_q;
            startArmed_q <= startArmed_q || (syncValid2_q && !startS2_q);
        end
    end

    // Sequencer next-state: abort from any busy state wins over everything else.
    always_comb begin
        state_d     = state_q;
        vector_d    = vector_q;
        settleCnt_d = settleCnt_q;
        errCount_d  = errCount_q;
        firstFail_d = firstFail_q;
        failSeen_d  = failSeen_q;
        if (abortS2_q && busy) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (startEdge && !abortS2_q) begin
                        state_d     = ST_DRIVE;
                        vector_d    = 8'h00;
                        errCount_d  = 4'd0;
                        firstFail_d = 8'h00;
                        failSeen_d  = 1'b0;
                    end
                end
                ST_DRIVE: begin
                    settleCnt_d = 4'd0;
                    state_d     = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settleCnt_q == 4'(SETTLE_CYCLES - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        settleCnt_d = settleCnt_q + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (sumMismatch) begin
                        if (errCount_q != ERR_SAT) begin
                            errCount_d = errCount_q + 4'd1;
                        end
                        if (!failSeen_q) begin
                            firstFail_d = vector_q;
                            failSeen_d  = 1'b1;
                        end
                    end
                    if (vector_q == 8'hFF) begin
                        state_d = ST_DONE;
                    end else begin
                        vector_d = vector_q + 8'd1;
                        state_d  = ST_DRIVE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vector_q    <= 8'h00;
            settleCnt_q <= 4'd0;
            errCount_q  <= 4'd0;
            firstFail_q <= 8'h00;
            failSeen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vector_q    <= vector_d;
            settleCnt_q <= settleCnt_d;
            errCount_q  <= errCount_d;
            firstFail_q <= firstFail_d;
            failSeen_q  <= failSeen_d;
        end
    end

    // Operand bus: live vector while busy, readout selection when done, quiet when idle.
    always_comb begin
        uo_out = 8'h00;
        if (busy) begin
            uo_out = vector_q;
        end else if (state_q == ST_DONE) begin
            uo_out = ui_in[5] ? firstFail_q : vector_q;
        end
    end

    // Status byte: error count stays visible after an abort for readout.
    always_comb begin
        statusBits           = 8'h00;
        statusBits[BUSY_BIT] = busy;
        statusBits[DONE_BIT] = (state_q == ST_DONE);
        statusBits[PASS_BIT] = (state_q == ST_DONE) && (errCount_q == 4'd0);
        statusBits[ZERO_BIT] = 1'b0;
        statusBits[7:4]      = errCount_q;
    end

    assign uio_out = statusBits;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_nibble_adder_checker.sv
// Self-checking bench: a behavioural adder (ideal or with injected faults)
// answers the checker, and a vector-sweep reference predicts the report.
module tb_tt_um_nibble_adder_checker;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         failSel = 1'b0;
    logic [4:0]   retSum;
    logic [7:0]   ui_in;
    logic [7:0]   uo_out;
    logic [7:0]   uio_in;
    logic [7:0]   uio_out;
    logic [7:0]   uio_oe;
    int           mode = 0;
    logic [255:0] badMask = '0;
    int           testsRun = 0;
    int           testsFailed = 0;

    tt_um_nibble_adder_checker #(.SETTLE_CYCLES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Adder under test: mode 0 ideal, 1 sum bit 4 stuck low, 2 wrong at 8'h3A, 3 wrong where badMask is set.
    function automatic logic [4:0] adderModel(input logic [7:0] v, input int m, input logic [255:0] mask);
        int s;
        s = int'(v[3:0]) + int'(v[7:4]);
        case (m)
            1: s = s % 16;
            2: if (v == 8'h3A) s = 0;
            3: if (mask[v]) s = (s + 1) % 32;
            default: ;
        endcase
        return 5'(s);
    endfunction

    assign retSum = adderModel(uo_out, mode, badMask);
    assign ui_in  = {start, abort, failSel, retSum};
    assign uio_in = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete run: predict the report by sweeping every operand pair, then launch and measure.
    task automatic applyStimulus(input int m, input bit repulse, input string tag);
        int nBad;
        int firstBad;
        int cycles;
        nBad     = 0;
        firstBad = -1;
        cycles   = 0;
        mode     = m;
        for (int v = 0; v < 256; v++) begin
            if (int'(adderModel(8'(v), m, badMask)) != (v % 16) + (v / 16)) begin
                nBad++;
                if (firstBad < 0) firstBad = v;
            end
        end
        start = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (uio_out[0]) cycles++;
            if (uio_out[1] && cycles > 0) break;
            if (k == 4) start = 1'b0;
            if (repulse && k == 300) start = 1'b1;
            if (repulse && k == 310) start = 1'b0;
            failSel = 1'($urandom_range(0, 1));
        end
        start   = 1'b0;
        failSel = 1'b0;
        #1;
        checkOutput({tag, ".runLen"}, cycles, 1024);
        checkOutput({tag, ".done"}, uio_out[1], 1'b1);
        checkOutput({tag, ".busy"}, uio_out[0], 1'b0);
        checkOutput({tag, ".pass"}, uio_out[2], nBad == 0);
        checkOutput({tag, ".errCount"}, uio_out[7:4], (nBad > 15) ? 15 : nBad);
        checkOutput({tag, ".lastVec"}, uo_out, 8'hFF);
        failSel = 1'b1;
        #1;
        checkOutput({tag, ".firstFail"}, uo_out, (firstBad < 0) ? 0 : firstBad);
        failSel = 1'b0;
        @(negedge clk);
    endtask

    // Launch a run and stop once the operand bus shows the given vector.
    task automatic runUntil(input logic [7:0] target, input string tag);
        bit found;
        found = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k == 4) start = 1'b0;
            if (uio_out[0] && uo_out == target) begin
                found = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checkOutput({tag, ".reached"}, found, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset.uo_out", uo_out, 8'h00);
        checkOutput("reset.uio_out", uio_out, 8'h00);
        checkOutput("reset.uio_oe", uio_oe, 8'hFF);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        applyStimulus(0, 1'b0, "ideal");
        // Lowest vector needing sum bit 4 is A=15,B=1, so that is the first failure here.
        applyStimulus(1, 1'b0, "stuck4");
        applyStimulus(2, 1'b0, "bad3A");

        badMask = '0;
        repeat ($urandom_range(1, 5)) badMask[$urandom_range(0, 255)] = 1'b1;
        applyStimulus(3, 1'b0, "randFew");
        badMask = '0;
        repeat ($urandom_range(0, 40)) badMask[$urandom_range(0, 255)] = 1'b1;
        applyStimulus(3, 1'b0, "randMany");

        applyStimulus(0, 1'b1, "repulse");

        // Abort mid-run, error count from 8'h3A must survive for readout.
        mode = 2;
        runUntil(8'h40, "abort");
        abort = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort.busy", uio_out[0], 1'b0);
        checkOutput("abort.done", uio_out[1], 1'b0);
        checkOutput("abort.pass", uio_out[2], 1'b0);
        checkOutput("abort.uo_out", uo_out, 8'h00);
        checkOutput("abort.errCount", uio_out[7:4], 4'd1);

        // Start edge while abort is held must be ignored.
        start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        checkOutput("abortWins.busy", uio_out[0], 1'b0);
        abort = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("abortWins.stillIdle", uio_out[0], 1'b0);
        applyStimulus(0, 1'b0, "postAbort");

        // Reset mid-run with start held high across release.
        mode = 0;
        runUntil(8'h80, "reset");
        start = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midReset.uo_out", uo_out, 8'h00);
        checkOutput("midReset.uio_out", uio_out, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("heldStart.busy", uio_out[0], 1'b0);
        checkOutput("heldStart.done", uio_out[1], 1'b0);
        checkOutput("heldStart.uo_out", uo_out, 8'h00);
        start = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(0, 1'b0, "postReset");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
